// File: rtl/clk_div_pkg.sv
// rtl/clk_div_pkg.sv - shared types and ratio clamping for the multi-channel clock divider
package clk_div_pkg;

  localparam int unsigned MIN_DIV = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } ch_state_e;

  typedef struct packed {
    logic [31:0] div;
    logic [31:0] high;
  } ratio_t;

  // Forces a ratio that always toggles: period >= 2, 0 < high < period.
  function automatic ratio_t clamp_ratio(input logic [31:0] div, input logic [31:0] high);
    ratio_t r;
    r.div  = (div < MIN_DIV) ? MIN_DIV : div;
    r.high = (high == 32'd0) ? 32'd1 : high;
    if (r.high >= r.div) r.high = r.div - 32'd1;
    return r;
  endfunction

endpackage

// File: rtl/clk_div_multi_channel.sv
// rtl/clk_div_multi_channel.sv - one divider channel: counter, shadow/active ratio, idle/run FSM
module clk_div_channel
  import clk_div_pkg::*;
#(
  parameter int          CNT_W       = 16,
  parameter int unsigned DEFAULT_DIV = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic             i_sync,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_div,
  input  logic [CNT_W-1:0] i_high,
  output logic             o_clk,
  output logic             o_tick,
  output logic             o_pend
);

  localparam logic [31:0] DIV_MAX    = (32'd1 << CNT_W) - 32'd1;
  localparam logic [31:0] DEF_DIV_IN = (DEFAULT_DIV > DIV_MAX) ? DIV_MAX : 32'(DEFAULT_DIV);
  localparam ratio_t      DEF_R      = clamp_ratio(DEF_DIV_IN, DEF_DIV_IN / 32'd2);
  localparam logic [CNT_W-1:0] DEF_DIV  = CNT_W'(DEF_R.div);
  localparam logic [CNT_W-1:0] DEF_HIGH = CNT_W'(DEF_R.high);

  ch_state_e        state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] div_a_q, div_a_d, high_a_q, high_a_d;
  logic [CNT_W-1:0] div_s_q, div_s_d, high_s_q, high_s_d;
  logic             pend_q, pend_d, clk_q, clk_d, tick_q, tick_d;

  ratio_t           ld_r;
  logic [CNT_W-1:0] ld_div, ld_high, cnt;
  logic             boundary;

  always_comb begin
    ld_r     = clamp_ratio(32'(i_div), 32'(i_high));
    ld_div   = CNT_W'(ld_r.div);
    ld_high  = CNT_W'(ld_r.high);
    // A channel coming out of IDLE always starts a fresh period.
    cnt      = (state_q == ST_IDLE) ? '0 : count_q;
    boundary = (cnt == div_a_q - 1'b1) || i_sync || !i_en;

    state_d  = i_en ? ST_RUN : ST_IDLE;
    count_d  = '0;
    clk_d    = 1'b0;
    tick_d   = 1'b0;
    div_a_d  = div_a_q;
    high_a_d = high_a_q;
    div_s_d  = div_s_q;
    high_s_d = high_s_q;
    pend_d   = pend_q;

    if (i_en) begin
      clk_d   = (cnt < high_a_q);
      tick_d  = (cnt == '0);
      count_d = boundary ? '0 : cnt + 1'b1;
    end

    // At a period boundary a fresh load bypasses the shadow; otherwise the shadow is promoted.
    if (boundary) begin
      if (i_load) begin
        div_a_d  = ld_div;
        high_a_d = ld_high;
        div_s_d  = ld_div;
        high_s_d = ld_high;
      end else if (pend_q) begin
        div_a_d  = div_s_q;
        high_a_d = high_s_q;
      end
      pend_d = 1'b0;
    end else if (i_load) begin
      div_s_d  = ld_div;
      high_s_d = ld_high;
      pend_d   = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      div_a_q  <= DEF_DIV;
      high_a_q <= DEF_HIGH;
      div_s_q  <= DEF_DIV;
      high_s_q <= DEF_HIGH;
      pend_q   <= 1'b0;
      clk_q    <= 1'b0;
      tick_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      div_a_q  <= div_a_d;
      high_a_q <= high_a_d;
      div_s_q  <= div_s_d;
      high_s_q <= high_s_d;
      pend_q   <= pend_d;
      clk_q    <= clk_d;
      tick_q   <= tick_d;
    end
  end

  assign o_clk  = clk_q;
  assign o_tick = tick_q;
  assign o_pend = pend_q;

endmodule

// File: rtl/clk_div_multi.sv
// rtl/clk_div_multi.sv - multi-channel programmable clock divider top
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int          NUM_CH      = 2,
  parameter int          CNT_W       = 16,
  parameter int unsigned DEFAULT_DIV = 2
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [NUM_CH-1:0]       i_en,
  input  logic                    i_sync,
  input  logic [NUM_CH-1:0]       i_load,
  input  logic [NUM_CH*CNT_W-1:0] i_div,
  input  logic [NUM_CH*CNT_W-1:0] i_high,
  output logic [NUM_CH-1:0]       o_clk,
  output logic [NUM_CH-1:0]       o_tick,
  output logic [NUM_CH-1:0]       o_pend
);

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    clk_div_channel #(
      .CNT_W      (CNT_W),
      .DEFAULT_DIV(DEFAULT_DIV)
    ) u_ch (
      .i_clk  (i_clk),
      .i_rst_n(i_rst_n),
      .i_en   (i_en[k]),
      .i_sync (i_sync),
      .i_load (i_load[k]),
      .i_div  (i_div[k*CNT_W +: CNT_W]),
      .i_high (i_high[k*CNT_W +: CNT_W]),
      .o_clk  (o_clk[k]),
      .o_tick (o_tick[k]),
      .o_pend (o_pend[k])
    );
  end

endmodule

// File: doc/clk_div_multi.md
Name: clk_div_multi

Overview:
- Multi-channel programmable clock divider.
- Generates NUM_CH independent divided clock-enable/square-wave outputs from one fabric clock, for HDMI pixel/audio/LED timing.
- Each channel has a runtime-programmable period and high time.
- Ratio changes are double-buffered and applied only at a period boundary, so no runt pulses.
- Channels can be started, stopped and phase-aligned by a global sync.

Parameters:
- NUM_CH, 2, number of independent divider channels (1..8).
- CNT_W, 16, width of the period/high-time counters and program words.
- DEFAULT_DIV, 2, reset period of every channel (clamped into 2..2^CNT_W-1).

Ports:
- i_clk  in  1  fabric clock; all logic on rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_en  in  NUM_CH  per-channel run enable.
- i_sync  in  1  one-cycle pulse; restarts all enabled channels in phase.
- i_load  in  NUM_CH  per-channel one-cycle load strobe for i_div/i_high.
- i_div  in  NUM_CH*CNT_W  period in i_clk cycles, channel k in bits [k*CNT_W +: CNT_W].
- i_high  in  NUM_CH*CNT_W  high time in i_clk cycles, same packing.
- o_clk  out  NUM_CH  registered divided clock.
- o_tick  out  NUM_CH  one-cycle pulse on the first high cycle of each period.
- o_pend  out  NUM_CH  shadow ratio loaded but not yet applied.

Behaviour:
- Reset (async, i_rst_n=0), all channels:
  - count=0; active div=DEFAULT_DIV; active high=DEFAULT_DIV/2; shadow=active.
  - o_clk=0; o_tick=0; o_pend=0.
- Per-channel state machine, two states:
  - IDLE: i_en[k]=0. count held 0, o_clk=0, o_tick=0. A load writes the active regs directly; o_pend stays 0.
  - RUN: i_en[k]=1. Transition IDLE->RUN on i_en rising; RUN->IDLE on i_en low, taking effect next cycle with o_clk=0. No partial-period completion.
- Counting in RUN:
  - count = count+1 each cycle; wraps to 0 when count==div_a-1.
  - o_clk <= (count < high_a); o_tick <= (count==0). One-cycle registered latency.
  - First cycle after entering RUN: o_clk=1, o_tick=1.
- Clamping, applied when a value is captured:
  - div<2 -> 2.
  - high==0 -> 1.
  - high>=div -> div-1.
  - Result: o_clk always toggles, and duty is never 0% or 100%.
- Load in RUN:
  - i_load[k] captures the clamped i_div/i_high slices into the shadow regs; o_pend[k]=1 next cycle.
  - At the next wrap cycle: active<=shadow, o_pend<=0. The new period starts at count=0.
- Simultaneous events:
  - Load on the wrap cycle: incoming values bypass the shadow and become active for the period starting next cycle; o_pend stays 0.
  - Load while o_pend=1: the shadow is overwritten (last write wins), still applied at the next wrap.
- i_sync:
  - Every RUN channel forces count<=0 next cycle, and pending shadows are applied on that cycle.
  - IDLE channels are unaffected.
  - i_sync coincident with a load: the new value is applied immediately, as on a wrap.
- Period/high arithmetic is unsigned CNT_W. Count never exceeds div_a-1, so there is no overflow.
- Reset asserted mid-period: outputs go to reset values immediately (async). The first RUN period after release uses the DEFAULT_DIV ratio.

Decomposition:
- Package clk_div_pkg holds:
  - localparam MIN_DIV=2;
  - the channel state enum {IDLE, RUN};
  - a function clamp_ratio(div, high) returning {div_c, high_c}.
- Sub-module clk_div_channel (one counter, shadow/active regs, FSM) is instantiated NUM_CH times in a generate loop. The top level only slices the buses and fans out i_sync.

Test Plan:
- Reset release, i_en=2'b01, DEFAULT_DIV=2 -> o_clk[0] toggles every cycle (1,0,1,0...); o_tick[0] on each high cycle; o_clk[1]=0 throughout.
- Channel 0 load div=5, high=2 mid-period of a div=4 period -> o_pend=1 until the wrap; current period completes at 4 cycles; then o_clk pattern 1,1,0,0,0 repeats; o_pend=0.
- Load div=1, high=0 -> clamped to div=2, high=1; output 1,0,1,0.
- Load div=6, high=9 -> clamped to high=5; output 1,1,1,1,1,0.
- Ch0 div=3, ch1 div=7 free-running; pulse i_sync -> both o_tick assert on the same cycle, one cycle after i_sync.
- Load asserted exactly on a wrap cycle -> new ratio is active in the immediately following period; o_pend never rises.
- Drop i_en[0] mid-high -> o_clk[0]=0 next cycle; re-enable -> o_clk=1, o_tick=1 on the first enabled cycle.
- i_rst_n pulsed low for half a cycle mid-period -> o_clk/o_tick/o_pend clear asynchronously; ratio returns to DEFAULT_DIV.
